// File: rtl/wb_regsrc_multi.sv
// WB-stage result selector and register-file write register for the MIPS pipeline.
// Optional forwarding/hazard outputs are enabled by defining WB_FWD_EN.
module wb_regsrc_multi #(
    parameter int DATA_W  = 32,
    parameter int REGF_W  = 5,
    parameter int NSRC    = 4,
    parameter int MEM_SRC = 1,
    parameter int SEL_W   = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [REGF_W-1:0]      in_regf,
    input  logic [NSRC*DATA_W-1:0] in_data,
    input  logic [2:0]             in_ld,
    input  logic [1:0]             in_addr_lo,
    input  logic                   mem_rvalid,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   flush,
    output logic                   wb_we,
    output logic [REGF_W-1:0]      wb_regf,
    output logic [DATA_W-1:0]      wb_data
`ifdef WB_FWD_EN
    ,
    output logic                   fwd_valid,
    output logic [REGF_W-1:0]      fwd_regf,
    output logic [DATA_W-1:0]      fwd_data,
    output logic                   fwd_pend
`endif
);

    typedef enum logic {
        S_IDLE,
        S_WAIT_MEM
    } state_t;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ld_t;

    localparam logic [SEL_W-1:0] MEM_SEL = SEL_W'(MEM_SRC);

    state_t              state_q, state_d;
    logic [REGF_W-1:0]   lat_regf_q, lat_regf_d;
    logic [2:0]          lat_ld_q, lat_ld_d;
    logic [1:0]          lat_lo_q, lat_lo_d;
    logic                wb_we_q, wb_we_d;
    logic [REGF_W-1:0]   wb_regf_q, wb_regf_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;

    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W-1:0]   load_data;
    logic [2:0]          align_ld;
    logic [1:0]          align_lo;
    logic                accept;

    // Out-of-range selects fall through to zero data but still write.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // While waiting, the response must be aligned with the load's own fields,
    // not with whatever upstream is presenting now.
    assign align_ld = (state_q == S_WAIT_MEM) ? lat_ld_q : in_ld;
    assign align_lo = (state_q == S_WAIT_MEM) ? lat_lo_q : in_addr_lo;

    generate
        if (DATA_W == 32) begin : g_align
            logic [7:0]  byte_v;
            logic [15:0] half_v;

            always_comb begin
                byte_v = mem_rdata[{align_lo, 3'b000} +: 8];
                half_v = align_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
                case (align_ld)
                    LD_H:    load_data = {{16{half_v[15]}}, half_v};
                    LD_HU:   load_data = {16'h0000, half_v};
                    LD_B:    load_data = {{24{byte_v[7]}}, byte_v};
                    LD_BU:   load_data = {24'h000000, byte_v};
                    default: load_data = mem_rdata;
                endcase
            end
        end else begin : g_noalign
            assign load_data = mem_rdata;
        end
    endgenerate

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid & in_ready;

    // NOTE: every output of this block gets a default first so no path
    // through the case statements can infer a latch.
    always_comb begin
        state_d    = state_q;
        lat_regf_d = lat_regf_q;
        lat_ld_d   = lat_ld_q;
        lat_lo_d   = lat_lo_q;
        wb_we_d    = 1'b0;
        wb_regf_d  = wb_regf_q;
        wb_data_d  = wb_data_q;

        if (flush) begin
            state_d    = S_IDLE;
            lat_regf_d = '0;
            lat_ld_d   = '0;
            lat_lo_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (in_sel == MEM_SEL) begin
                            if (mem_rvalid) begin
                                wb_we_d   = (in_regf != '0);
                                wb_regf_d = in_regf;
                                wb_data_d = load_data;
                            end else begin
                                lat_regf_d = in_regf;
                                lat_ld_d   = in_ld;
                                lat_lo_d   = in_addr_lo;
                                state_d    = S_WAIT_MEM;
                            end
                        end else begin
                            wb_we_d   = (in_regf != '0);
                            wb_regf_d = in_regf;
                            wb_data_d = sel_data;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        wb_we_d   = (lat_regf_q != '0);
                        wb_regf_d = lat_regf_q;
                        wb_data_d = load_data;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values computed above.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            lat_regf_q <= '0;
            lat_ld_q   <= '0;
            lat_lo_q   <= '0;
            wb_we_q    <= 1'b0;
            wb_regf_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            lat_regf_q <= lat_regf_d;
            lat_ld_q   <= lat_ld_d;
            lat_lo_q   <= lat_lo_d;
            wb_we_q    <= wb_we_d;
            wb_regf_q  <= wb_regf_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_regf = wb_regf_q;
    assign wb_data = wb_data_q;

`ifdef WB_FWD_EN
    // A pending load exposes its destination so hazard logic can stall on it.
    assign fwd_pend  = (state_q == S_WAIT_MEM);
    assign fwd_valid = wb_we_q;
    assign fwd_regf  = fwd_pend ? lat_regf_q : wb_regf_q;
    assign fwd_data  = wb_data_q;
`endif

endmodule

// File: tb/tb_wb_regsrc_multi.sv
// Directed self-checking bench for wb_regsrc_multi: ALU writes, load alignment,
// load wait, $0 suppression, flush and asynchronous reset.
module tb_wb_regsrc_multi;

    localparam int DATA_W = 32;
    localparam int REGF_W = 5;
    localparam int NSRC   = 4;
    localparam int SEL_W  = 2;

    logic                   clk;
    logic                   resetn;
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       in_sel;
    logic [REGF_W-1:0]      in_regf;
    logic [NSRC*DATA_W-1:0] in_data;
    logic [2:0]             in_ld;
    logic [1:0]             in_addr_lo;
    logic                   mem_rvalid;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   flush;
    logic                   wb_we;
    logic [REGF_W-1:0]      wb_regf;
    logic [DATA_W-1:0]      wb_data;
`ifdef WB_FWD_EN
    logic                   fwd_valid;
    logic [REGF_W-1:0]      fwd_regf;
    logic [DATA_W-1:0]      fwd_data;
    logic                   fwd_pend;
`endif

    int total = 0;
    int bad   = 0;

    wb_regsrc_multi #(
        .DATA_W (DATA_W),
        .REGF_W (REGF_W),
        .NSRC   (NSRC),
        .MEM_SRC(1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_regf   (in_regf),
        .in_data   (in_data),
        .in_ld     (in_ld),
        .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .flush     (flush),
        .wb_we     (wb_we),
        .wb_regf   (wb_regf),
        .wb_data   (wb_data)
`ifdef WB_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_regf  (fwd_regf),
        .fwd_data  (fwd_data),
        .fwd_pend  (fwd_pend)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_sel     = '0;
        in_regf    = '0;
        in_data    = '0;
        in_ld      = 3'd0;
        in_addr_lo = 2'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        flush      = 1'b0;
    endtask

    task automatic drive_alu(input logic [SEL_W-1:0] sel, input logic [REGF_W-1:0] regf,
                             input logic [DATA_W-1:0] data);
        idle_inputs();
        in_valid = 1'b1;
        in_sel   = sel;
        in_regf  = regf;
        in_data[sel*DATA_W +: DATA_W] = data;
    endtask

    task automatic drive_load(input logic [2:0] ld, input logic [1:0] lo,
                              input logic [REGF_W-1:0] regf, input logic rv,
                              input logic [DATA_W-1:0] rdata);
        idle_inputs();
        in_valid   = 1'b1;
        in_sel     = 2'd1;
        in_regf    = regf;
        in_ld      = ld;
        in_addr_lo = lo;
        mem_rvalid = rv;
        mem_rdata  = rdata;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #12;
        total++;
        if (wb_we !== 1'b0 || wb_regf !== 5'd0 || wb_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs got we=%0b regf=%0d data=%08h want 0/0/0", wb_we, wb_regf, wb_data);
        end
        resetn = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%0b want=1", in_ready);
        end
    endtask

    task automatic test_alu();
        drive_alu(2'd0, 5'd8, 32'h1234_5678);
        tick();
        total++;
        if (wb_we !== 1'b1 || wb_regf !== 5'd8 || wb_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL alu_write got we=%0b regf=%0d data=%08h want 1/8/12345678", wb_we, wb_regf, wb_data);
        end
        idle_inputs();
        tick();
        total++;
        if (wb_we !== 1'b0) begin
            bad++;
            $display("FAIL alu_pulse got we=%0b want=0", wb_we);
        end
    endtask

    task automatic test_back_to_back();
        drive_alu(2'd2, 5'd31, 32'hCAFE_F00D);
        tick();
        total++;
        if (wb_we !== 1'b1 || wb_regf !== 5'd31 || wb_data !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL b2b_src2 got we=%0b regf=%0d data=%08h want 1/31/cafef00d", wb_we, wb_regf, wb_data);
        end
        drive_alu(2'd3, 5'd17, 32'h0BAD_BEEF);
        in_data[2*DATA_W +: DATA_W] = 32'h1111_1111;
        tick();
        total++;
        if (wb_we !== 1'b1 || wb_regf !== 5'd17 || wb_data !== 32'h0BAD_BEEF) begin
            bad++;
            $display("FAIL b2b_src3 got we=%0b regf=%0d data=%08h want 1/17/0badbeef", wb_we, wb_regf, wb_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_same();
        logic [2:0]        ld_v  [7];
        logic [1:0]        lo_v  [7];
        logic [DATA_W-1:0] rd_v  [7];
        logic [DATA_W-1:0] exp_v [7];
        ld_v[0] = 3'd3; lo_v[0] = 2'd2; rd_v[0] = 32'h0080_0000; exp_v[0] = 32'hFFFF_FF80;
        ld_v[1] = 3'd4; lo_v[1] = 2'd2; rd_v[1] = 32'h0080_0000; exp_v[1] = 32'h0000_0080;
        ld_v[2] = 3'd3; lo_v[2] = 2'd1; rd_v[2] = 32'h0000_7F00; exp_v[2] = 32'h0000_007F;
        ld_v[3] = 3'd2; lo_v[3] = 2'd0; rd_v[3] = 32'h1234_F00D; exp_v[3] = 32'h0000_F00D;
        ld_v[4] = 3'd1; lo_v[4] = 2'd0; rd_v[4] = 32'h1234_F00D; exp_v[4] = 32'hFFFF_F00D;
        ld_v[5] = 3'd0; lo_v[5] = 2'd3; rd_v[5] = 32'h89AB_CDEF; exp_v[5] = 32'h89AB_CDEF;
        ld_v[6] = 3'd7; lo_v[6] = 2'd1; rd_v[6] = 32'h89AB_CDEF; exp_v[6] = 32'h89AB_CDEF;
        for (int i = 0; i < 7; i++) begin
            drive_load(ld_v[i], lo_v[i], 5'd5, 1'b1, rd_v[i]);
            tick();
            total++;
            if (wb_we !== 1'b1 || wb_regf !== 5'd5 || wb_data !== exp_v[i]) begin
                bad++;
                $display("FAIL load_same[%0d] got we=%0b regf=%0d data=%08h want 1/5/%08h",
                         i, wb_we, wb_regf, wb_data, exp_v[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_wait();
        drive_load(3'd1, 2'd2, 5'd3, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            // Upstream changes its offer; the latched load fields must win.
            in_ld      = 3'd3;
            in_addr_lo = 2'd0;
            in_regf    = 5'd9;
            total++;
            if (in_ready !== 1'b0 || wb_we !== 1'b0) begin
                bad++;
                $display("FAIL load_wait_stall[%0d] got ready=%0b we=%0b want 0/0", c, in_ready, wb_we);
            end
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_ABCD;
        tick();
        total++;
        if (in_ready !== 1'b1 || wb_we !== 1'b1 || wb_regf !== 5'd3 || wb_data !== 32'hFFFF_8001) begin
            bad++;
            $display("FAIL load_wait_done got ready=%0b we=%0b regf=%0d data=%08h want 1/1/3/ffff8001",
                     in_ready, wb_we, wb_regf, wb_data);
        end
        idle_inputs();
        tick();
        total++;
        if (wb_we !== 1'b0) begin
            bad++;
            $display("FAIL load_wait_pulse got we=%0b want=0", wb_we);
        end
    endtask

    task automatic test_reg0();
        drive_alu(2'd0, 5'd0, 32'hAAAA_5555);
        tick();
        total++;
        if (wb_we !== 1'b0) begin
            bad++;
            $display("FAIL reg0_alu got we=%0b want=0", wb_we);
        end
        drive_load(3'd0, 2'd0, 5'd0, 1'b0, 32'h0);
        tick();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        tick();
        total++;
        if (wb_we !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reg0_load got we=%0b ready=%0b want 0/1", wb_we, in_ready);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        drive_load(3'd0, 2'd0, 5'd9, 1'b0, 32'h0);
        tick();
        idle_inputs();
        flush      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2468_ACE0;
        tick();
        total++;
        if (wb_we !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_wait got we=%0b ready=%0b want 0/1", wb_we, in_ready);
        end
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2468_ACE0;
        tick();
        total++;
        if (wb_we !== 1'b0) begin
            bad++;
            $display("FAIL flush_late_rvalid got we=%0b want=0", wb_we);
        end
        drive_alu(2'd0, 5'd4, 32'h0000_0044);
        flush = 1'b1;
        tick();
        total++;
        if (wb_we !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_drop got we=%0b want=0", wb_we);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        drive_alu(2'd0, 5'd7, 32'hDEAD_BEEF);
        tick();
        drive_load(3'd0, 2'd0, 5'd6, 1'b0, 32'h0);
        tick();
        idle_inputs();
        total++;
        if (in_ready !== 1'b0 || wb_regf !== 5'd7 || wb_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL areset_pre got ready=%0b regf=%0d data=%08h want 0/7/deadbeef",
                     in_ready, wb_regf, wb_data);
        end
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (wb_we !== 1'b0 || wb_regf !== 5'd0 || wb_data !== 32'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL areset_now got we=%0b regf=%0d data=%08h ready=%0b want 0/0/0/1",
                     wb_we, wb_regf, wb_data, in_ready);
        end
        #3;
        resetn = 1'b1;
        tick();
        drive_alu(2'd0, 5'd2, 32'h0000_0055);
        tick();
        total++;
        if (wb_we !== 1'b1 || wb_regf !== 5'd2 || wb_data !== 32'h0000_0055) begin
            bad++;
            $display("FAIL areset_after got we=%0b regf=%0d data=%08h want 1/2/00000055", wb_we, wb_regf, wb_data);
        end
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        total++;
        if (wb_we !== 1'b0 || wb_data !== 32'h0000_0055) begin
            bad++;
            $display("FAIL idle_rvalid_ignored got we=%0b data=%08h want 0/00000055", wb_we, wb_data);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_same();
        test_load_wait();
        test_reg0();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regsrc_multi.md
Name: wb_regsrc_multi

Overview:
Parametrised writeback source selector and result register for the WB stage of the MIPS pipeline.
- Selects one of NSRC result sources per instruction.
- For memory-sourced results, waits on the data-memory read response and byte-aligns and sign/zero-extends the load data.
- Registers the final (regf, data, we) triple toward the register file.
- Back-pressures the pipeline while a load response is outstanding.

Parameters:
DATA_W, 32, datapath width in bits (32 only for load alignment; other widths pass data unaligned)
REGF_W, 5, register-file index width
NSRC, 4, number of result sources; source index MEM_SRC selects load data
MEM_SRC, 1, source index that denotes a memory load
SEL_W, $clog2(NSRC), width of the source select

Ports:
clk  input  1  pipeline clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an instruction this cycle
in_sel  input  SEL_W  result source index
in_regf  input  REGF_W  destination register; 0 means no write
in_data  input  NSRC*DATA_W  packed non-memory sources, source k at bits [k*DATA_W +: DATA_W]
in_ld  input  3  load type: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, others treated as LW
in_addr_lo  input  2  low address bits of the load
mem_rvalid  input  1  data-memory read response valid
mem_rdata  input  DATA_W  data-memory read word
flush  input  1  discard any pending load and the registered result
wb_we  output  1  register-file write enable, one cycle per retired instruction
wb_regf  output  REGF_W  register-file write index
wb_data  output  DATA_W  register-file write data

Behaviour:
- Reset (resetn low, asynchronous):
  - wb_we=0, wb_regf=0, wb_data=0.
  - FSM goes to IDLE and all latched fields clear.
  - in_ready=1 once reset is released.
- FSM states: IDLE and WAIT_MEM.
- IDLE:
  - in_ready=1.
  - On accept (in_valid & in_ready) with in_sel != MEM_SRC: next edge sets wb_data=in_data[in_sel], wb_regf=in_regf, wb_we=(in_regf!=0). Latency is 1 cycle.
  - On accept with in_sel==MEM_SRC and mem_rvalid=1 in the same cycle: aligned load data is registered on that edge. Latency is 1 cycle.
  - On accept with in_sel==MEM_SRC and mem_rvalid=0: latch regf, ld, addr_lo and go to WAIT_MEM. wb_we=0 next cycle.
  - in_sel >= NSRC: selected data is 0; the write still occurs.
- WAIT_MEM:
  - in_ready=0.
  - On mem_rvalid, register the aligned data with the latched regf, set wb_we=(regf!=0), and return to IDLE. in_ready rises the same edge.
  - mem_rvalid in IDLE with no load accepted is ignored.
- wb_we is a single-cycle pulse: cleared on any edge without a retirement.
- Load alignment:
  - Byte lane is addr_lo; half lane is addr_lo[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW ignores addr_lo.
  - Misaligned LH/LW is not checked here: the half lane is addr_lo[1], and the full word is used for LW.
- Flush:
  - Synchronous.
  - The next edge forces wb_we=0 and FSM=IDLE.
  - The instruction offered that cycle is dropped.
  - A mem_rvalid arriving in the flush cycle is discarded.
  - Flush has priority over every other event.

Optional Feature:
Macro WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_regf (REGF_W) and fwd_data (DATA_W).
  - These mirror wb_we, wb_regf and wb_data.
  - In WAIT_MEM they additionally present fwd_valid=0 with fwd_regf=latched regf, so hazard logic can detect a pending load destination.
  - Also adds output fwd_pend (1), high in WAIT_MEM.
  - Reset value of all four outputs is 0.
- Undefined: the ports do not exist and there is no extra logic.

Test Plan:
- ALU write: in_sel=0, in_data[0]=0x12345678, regf=8, one cycle -> next cycle wb_we=1, wb_regf=8, wb_data=0x12345678; following cycle wb_we=0.
- Load same-cycle: sel=MEM_SRC, LB, addr_lo=2, mem_rvalid=1, rdata=0x00800000 -> next cycle wb_data=0xFFFFFF80. LBU with the same inputs -> 0x00000080.
- Load wait: LH, addr_lo=2, regf=3, mem_rvalid low for 3 cycles, then rdata=0x8001ABCD -> in_ready=0 for 3 cycles, then wb_data=0xFFFF8001, wb_regf=3, wb_we=1 for one cycle.
- Register 0: ALU op with regf=0 -> wb_we stays 0. The same for a load to $0 after the response arrives.
- Flush in WAIT_MEM, then mem_rvalid in the same cycle -> no write, FSM=IDLE, in_ready=1 on the next cycle.
- Async reset asserted in WAIT_MEM mid-cycle -> outputs 0 immediately without a clock edge. After release the stage accepts a new ALU op normally.
